// File: rtl/fixed_lat_resp_pkg.sv
// Shared types and sizing helpers for the fixed-latency response buffer.
package fixed_lat_resp_pkg;

  localparam int unsigned DefaultDataWidth = 101;

  typedef logic [DefaultDataWidth-1:0] resp_payload_t;

  // Width of a counter that must hold every value 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fixed_lat_resp_ring.sv
// Circular response storage with wrap at any NumEntries, simultaneous push/pop
// at every fill level and a synchronous clear.
module fixed_lat_resp_ring
  import fixed_lat_resp_pkg::*;
#(
  parameter int unsigned NumEntries = 4,
  parameter int unsigned DataWidth  = DefaultDataWidth,
  localparam int unsigned CntW      = cnt_width(NumEntries)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DataWidth-1:0] push_data,
  output logic [DataWidth-1:0] head_data,
  output logic [CntW-1:0]      count
);

  localparam int unsigned PtrW = (NumEntries > 1) ? $clog2(NumEntries) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(NumEntries - 1);

  logic [DataWidth-1:0] mem [NumEntries];
  logic [PtrW-1:0]      wr_ptr;
  logic [PtrW-1:0]      rd_ptr;
  logic                 full;
  logic                 empty;
  logic                 do_push;
  logic                 do_pop;

  assign full      = (count == CntW'(NumEntries));
  assign empty     = (count == '0);
  // A full ring still takes a push when the head leaves in the same cycle.
  assign do_push   = push && (!full || pop);
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop) begin
        count <= count + CntW'(1);
      end else if (!do_push && do_pop) begin
        count <= count - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fixed_lat_resp_buf.sv
// Credit-based response buffer behind a fixed-latency delay line, with flush/drop handling.
// Optional FIXED_LAT_RESP_BUF_FALL_THROUGH_EN: same-cycle bypass when the ring is empty.
module fixed_lat_resp_buf
  import fixed_lat_resp_pkg::*;
#(
  parameter int unsigned Depth      = 1,
  parameter int unsigned NumEntries = 4,
  parameter int unsigned DataWidth  = DefaultDataWidth,
  localparam int unsigned CntW      = cnt_width(NumEntries)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 resp_valid_i,
  input  logic [DataWidth-1:0] resp_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth-1:0] out_data_o,
  output logic [CntW-1:0]      credits_o
);

  if (NumEntries == 0) begin : g_bad_cfg
    $error("fixed_lat_resp_buf: NumEntries must be at least 1");
  end

  logic [CntW-1:0]      credits;
  logic [CntW-1:0]      inflight;
  logic [CntW-1:0]      inflight_next;
  logic [CntW-1:0]      drop_cnt;
  logic [CntW-1:0]      fill;
  logic [DataWidth-1:0] head;
  logic [DataWidth-1:0] payload;
  logic                 issue;
  logic                 accept;
  logic                 dropping;
  logic                 empty;
  logic                 full;
  logic                 push;
  logic                 pop;
  logic                 handshake;
  logic                 credit_ret;

  assign req_ready_o   = (credits != '0);
  assign credits_o     = credits;
  assign issue         = req_valid_i && req_ready_o;
  assign accept        = resp_valid_i && (drop_cnt == '0);
  assign dropping      = resp_valid_i && (drop_cnt != '0);
  assign empty         = (fill == '0);
  assign full          = (fill == CntW'(NumEntries));
  assign pop           = out_ready_i && !empty;
  assign inflight_next = inflight + CntW'(issue) - CntW'(resp_valid_i);

`ifdef FIXED_LAT_RESP_BUF_FALL_THROUGH_EN
  logic bypass;
  // An accepted response facing an empty ring is offered at once; if taken it never lands.
  assign bypass      = accept && empty;
  assign out_valid_o = !empty || bypass;
  assign payload     = empty ? resp_data_i : head;
  assign push        = accept && !(bypass && out_ready_i);
`else
  assign out_valid_o = !empty;
  assign payload     = head;
  assign push        = accept;
`endif

  assign handshake  = out_valid_o && out_ready_i;
  assign credit_ret = handshake || dropping;
  assign out_data_o = out_valid_o ? payload : '0;

  fixed_lat_resp_ring #(
    .NumEntries (NumEntries),
    .DataWidth  (DataWidth)
  ) u_ring (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear     (flush_i),
    .push      (push),
    .pop       (pop),
    .push_data (resp_data_i),
    .head_data (head),
    .count     (fill)
  );

  // Flush re-bases credits on what is still in the delay line; ring contents are simply lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      credits  <= CntW'(NumEntries);
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight_next;
      if (flush_i) begin
        drop_cnt <= inflight_next;
        credits  <= CntW'(NumEntries) - inflight_next;
      end else begin
        if (dropping) drop_cnt <= drop_cnt - CntW'(1);
        if (issue && !credit_ret) begin
          credits <= credits - CntW'(1);
        end else if (!issue && credit_ret) begin
          credits <= credits + CntW'(1);
        end
      end
    end
  end

  a_room_for_resp: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(accept && full && !pop));

  a_inflight_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    32'(inflight) <= Depth);

endmodule

// File: tb/tb_fixed_lat_resp_buf.sv
// Randomised bench for fixed_lat_resp_buf: two instances (4 and 3 entries) fed by a
// bench-side delay line of selectable length and checked every cycle against a queue model.
module tb_fixed_lat_resp_buf;

  localparam int DW = 101;
  localparam int N0 = 4;
  localparam int N1 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          flush      [2];
  logic          req_valid  [2];
  logic          req_ready  [2];
  logic          resp_valid [2];
  logic [DW-1:0] resp_data  [2];
  logic          out_valid  [2];
  logic          out_ready  [2];
  logic [DW-1:0] out_data   [2];
  logic [2:0]    credits0;
  logic [1:0]    credits1;

  fixed_lat_resp_buf #(.Depth(3), .NumEntries(N0), .DataWidth(DW)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[0]),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .resp_valid_i(resp_valid[0]), .resp_data_i(resp_data[0]),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
    .out_data_o(out_data[0]), .credits_o(credits0)
  );

  fixed_lat_resp_buf #(.Depth(3), .NumEntries(N1), .DataWidth(DW)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[1]),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .resp_valid_i(resp_valid[1]), .resp_data_i(resp_data[1]),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
    .out_data_o(out_data[1]), .credits_o(credits1)
  );

  // Behavioural model state and the bench-side delay line.
  int            cred [2];
  int            infl [2];
  int            drop [2];
  logic [DW-1:0] mq0 [$];
  logic [DW-1:0] mq1 [$];
  logic          pv [2][3];
  logic [DW-1:0] pd [2][3];
  int            dl [2];
  logic [DW-1:0] req_data [2];

  int checks;
  int failures;
  int cyc;

  function automatic int nent(input int k);
    return (k == 0) ? N0 : N1;
  endfunction

  function automatic int dut_cred(input int k);
    return (k == 0) ? int'(credits0) : int'(credits1);
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [DW-1:0] qfront(input int k);
    return (k == 0) ? mq0[0] : mq1[0];
  endfunction

  task automatic qpop(input int k);
    if (k == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
  endtask

  task automatic qpush(input int k, input logic [DW-1:0] d);
    if (k == 0) mq0.push_back(d); else mq1.push_back(d);
  endtask

  task automatic qclear(input int k);
    if (k == 0) mq0.delete(); else mq1.delete();
  endtask

  function automatic bit m_bypass(input int k);
`ifdef FIXED_LAT_RESP_BUF_FALL_THROUGH_EN
    return resp_valid[k] && (drop[k] == 0) && (qsize(k) == 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_valid(input int k);
    return (qsize(k) > 0) || m_bypass(k);
  endfunction

  function automatic logic [DW-1:0] m_data(input int k);
    return (qsize(k) > 0) ? qfront(k) : resp_data[k];
  endfunction

  function automatic logic [DW-1:0] rnd_payload();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  task automatic chk(input string name, input int k, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] cycle %0d: got %0h expected %0h", name, k, cyc, act, exp);
    end
  endtask

  task automatic cmp_cycle();
    for (int k = 0; k < 2; k++) begin
      chk("credits", k, dut_cred(k), cred[k]);
      chk("cred_range", k, dut_cred(k) <= nent(k), 1);
      chk("req_ready", k, req_ready[k], cred[k] != 0);
      chk("out_valid", k, out_valid[k], m_valid(k));
      if (m_valid(k)) chk("out_data", k, out_data[k], m_data(k));
    end
  endtask

  task automatic model_update(input int k, input bit iss);
    bit acc;
    bit dr;
    bit pop;
    int inf_n;
    acc   = resp_valid[k] && (drop[k] == 0);
    dr    = resp_valid[k] && (drop[k] != 0);
    pop   = m_valid(k) && out_ready[k];
    inf_n = infl[k] + int'(iss) - int'(resp_valid[k]);
    if (qsize(k) > 0) begin
      if (pop) qpop(k);
      if (acc) qpush(k, resp_data[k]);
    end else if (acc && !pop) begin
      qpush(k, resp_data[k]);
    end
    if (flush[k]) begin
      qclear(k);
      drop[k] = inf_n;
      cred[k] = nent(k) - inf_n;
    end else begin
      cred[k] = cred[k] + int'(pop || dr) - int'(iss);
      if (dr) drop[k] = drop[k] - 1;
    end
    infl[k] = inf_n;
  endtask

  task automatic step();
    bit iss;
    @(negedge clk);
    cmp_cycle();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      iss = req_valid[k] && (cred[k] != 0);
      model_update(k, iss);
      for (int s = 2; s > 0; s--) begin
        pv[k][s] = pv[k][s-1];
        pd[k][s] = pd[k][s-1];
      end
      pv[k][0] = iss;
      pd[k][0] = req_data[k];
    end
    cyc++;
    #1;
    for (int k = 0; k < 2; k++) begin
      resp_valid[k] = pv[k][dl[k]-1];
      resp_data[k]  = pd[k][dl[k]-1];
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      flush[k] = 1'b0; req_valid[k] = 1'b0; out_ready[k] = 1'b0;
      resp_valid[k] = 1'b0; resp_data[k] = '0; req_data[k] = '0;
      for (int s = 0; s < 3; s++) begin
        pv[k][s] = 1'b0;
        pd[k][s] = '0;
      end
      cred[k] = nent(k); infl[k] = 0; drop[k] = 0;
      qclear(k);
    end
    #1;
    chk("rst_credits", 0, credits0, 4);
    chk("rst_credits", 1, credits1, 3);
    for (int k = 0; k < 2; k++) begin
      chk("rst_req_ready", k, req_ready[k], 1);
      chk("rst_out_valid", k, out_valid[k], 0);
      chk("rst_out_data", k, out_data[k], 0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; out_ready[k] = 1'b1; flush[k] = 1'b0;
    end
    repeat (n) step();
  endtask

  task automatic set_depth(input int d);
    dl[0] = d;
    dl[1] = d;
  endtask

  task automatic rand_phase(input int ncyc, input int d, input int preq, input int prdy, input int pfl);
    set_depth(d);
    repeat (ncyc) begin
      for (int k = 0; k < 2; k++) begin
        req_valid[k] = ($urandom_range(0, 99) < preq);
        out_ready[k] = ($urandom_range(0, 99) < prdy);
        flush[k]     = ($urandom_range(0, 99) < pfl);
        req_data[k]  = rnd_payload();
      end
      step();
    end
  endtask

  initial begin
    int            pops;
    int            npop;
    logic [DW-1:0] popped [8];
    logic [DW-1:0] pat;
    checks = 0; failures = 0; cyc = 0;
    set_depth(1);
    #2;
    do_reset();

    // Back-to-back issue with a consumer that never stalls.
    pops = 0;
    for (int c = 0; c < 20; c++) begin
      for (int k = 0; k < 2; k++) begin
        req_valid[k] = 1'b1; out_ready[k] = 1'b1; req_data[k] = rnd_payload();
      end
      #1;
      if (c >= 10 && out_valid[0]) pops++;
      step();
    end
    #1;
    chk("stream_pops", 0, pops, 10);
`ifdef FIXED_LAT_RESP_BUF_FALL_THROUGH_EN
    chk("stream_credits", 0, credits0, 3);
`else
    chk("stream_credits", 0, credits0, 2);
`endif
    drain(6);

    // Fill with a stalled consumer, then drain in order.
    for (int i = 0; i < 4; i++) begin
      pat = DW'(10 + i);
      for (int k = 0; k < 2; k++) begin
        req_valid[k] = 1'b1; out_ready[k] = 1'b0; req_data[k] = pat;
      end
      step();
    end
    #1;
    chk("fill_ready", 0, req_ready[0], 0);
    for (int k = 0; k < 2; k++) req_valid[k] = 1'b0;
    step();
    npop = 0;
    for (int k = 0; k < 2; k++) out_ready[k] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (out_valid[0] && npop < 8) begin
        popped[npop] = out_data[0];
        npop++;
      end
      step();
    end
    chk("fill_pops", 0, npop, 4);
    for (int i = 0; i < 4 && i < npop; i++) begin
      pat = DW'(10 + i);
      chk("fill_order", i, popped[i], pat);
    end
    chk("fill_credits", 0, credits0, 4);

    rand_phase(300, 1, 70, 50, 0);
    drain(8);
    rand_phase(300, 3, 80, 60, 0);
    drain(8);

    // Flush alongside the third of three back-to-back issues on a 3-cycle line.
    set_depth(3);
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 2; k++) begin
        req_valid[k] = 1'b1; out_ready[k] = 1'b1; flush[k] = (i == 2); req_data[k] = rnd_payload();
      end
      step();
    end
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; flush[k] = 1'b0;
    end
    #1;
    chk("flush_credits", 0, credits0, 1);
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("flush_no_out", 0, out_valid[0], 0);
      step();
    end
    chk("flush_restore", 0, credits0, 4);
    drain(4);

    rand_phase(400, 3, 75, 60, 6);
    drain(8);
    rand_phase(300, 2, 75, 40, 6);

    // Asynchronous reset in the middle of traffic.
    do_reset();

    set_depth(1);
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b1; out_ready[k] = 1'b1; req_data[k] = DW'(8'h55);
    end
    step();
    for (int k = 0; k < 2; k++) req_valid[k] = 1'b0;
    #1;
`ifdef FIXED_LAT_RESP_BUF_FALL_THROUGH_EN
    chk("lat_valid_n", 0, out_valid[0], 1);
    chk("lat_data_n", 0, out_data[0], 8'h55);
`else
    chk("lat_valid_n", 0, out_valid[0], 0);
`endif
    step();
    #1;
`ifdef FIXED_LAT_RESP_BUF_FALL_THROUGH_EN
    chk("lat_valid_n1", 0, out_valid[0], 0);
    chk("lat_credits_n1", 0, credits0, 4);
`else
    chk("lat_valid_n1", 0, out_valid[0], 1);
    chk("lat_data_n1", 0, out_data[0], 8'h55);
`endif
    drain(4);
    rand_phase(200, 1, 60, 70, 4);
    drain(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
